// File: rtl/uart_frame_pkg.sv
// Shared types for the UART frame assembler and the status/LED logic.
//   SOF_BYTE_DEFAULT : default start-of-frame delimiter
//   state_e          : frame parser / burst FSM states
//   err_code_e       : reason a frame was dropped
package uart_frame_pkg;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_WAIT_DST,
        S_BURST
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_CHK,
        ERR_LEN,
        ERR_TIMEOUT
    } err_code_e;

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port payload buffer, DATA_WIDTH x DEPTH, registered read.
// Contents are not reset so the array maps onto distributed/block RAM.
//   i_clk     : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_en   : read strobe; o_rd_data updates on the next edge
//   i_rd_addr : read address
//   o_rd_data : registered read data
module frame_buffer_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            o_rd_data <= mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/uart_frame_assembler.sv
// Parses sparse UART RX bytes into SOF/LEN/payload/XOR-checksum frames,
// buffers the payload and, on a good checksum, replays it as one gap-free
// burst framed by o_first/o_last. Bad, oversize or stalled frames are dropped
// with a one-clock error pulse.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_rx_data/i_rx_valid: RX byte and its 1-clk strobe
//   i_dst_ready         : downstream idle, burst may start
//   o_data/o_valid      : payload burst, o_first/o_last mark its ends
//   o_err_chk/_len/_timeout : frame dropped pulses
//   o_overrun           : RX byte discarded while a frame awaits delivery
//   o_busy              : FSM not idle
module uart_frame_assembler
    import uart_frame_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           MAX_LEN        = 256,
    parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = DATA_WIDTH'(SOF_BYTE_DEFAULT),
    parameter int unsigned           TIMEOUT_CYCLES = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_dst_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_first,
    output logic                  o_last,
    output logic                  o_err_chk,
    output logic                  o_err_len,
    output logic                  o_err_timeout,
    output logic                  o_overrun,
    output logic                  o_busy
);

    localparam int unsigned   PW       = $clog2(MAX_LEN);
    localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    err_code_e             err;
    logic [PW-1:0]         wr_ptr, rd_ptr, rd_addr, last_idx;
    logic [DATA_WIDTH-1:0] chk, ram_q;
    logic [TW-1:0]         tmo_cnt;
    logic                  in_frame, tmo_hit, len_ok;
    logic                  wr_en, rd_en, rd_first, rd_last, overrun;
    logic                  s1_valid, s1_first, s1_last;

    assign in_frame = state_q inside {S_LEN, S_PAYLOAD, S_CHK};
    assign tmo_hit  = in_frame && (tmo_cnt == TMO_LAST);
    assign len_ok   = (32'(i_rx_data) >= 32'd2) && (32'(i_rx_data) <= 32'(MAX_LEN));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Read of beat 0 is issued from S_WAIT_DST on the clock dst_ready is seen,
    // so the registered RAM plus output stage still land o_first two clocks
    // after the checksum byte.
    always_comb begin
        state_d  = state_q;
        err      = ERR_NONE;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = rd_ptr;
        rd_first = 1'b0;
        rd_last  = 1'b0;
        overrun  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_rx_valid && i_rx_data == SOF_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (tmo_hit) begin
                    err     = ERR_TIMEOUT;
                    state_d = S_IDLE;
                end else if (i_rx_valid) begin
                    if (len_ok) begin
                        state_d = S_PAYLOAD;
                    end else begin
                        err     = ERR_LEN;
                        state_d = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (tmo_hit) begin
                    err     = ERR_TIMEOUT;
                    state_d = S_IDLE;
                end else if (i_rx_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == last_idx) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (tmo_hit) begin
                    err     = ERR_TIMEOUT;
                    state_d = S_IDLE;
                end else if (i_rx_valid) begin
                    if (i_rx_data == chk) begin
                        state_d = S_WAIT_DST;
                    end else begin
                        err     = ERR_CHK;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_DST: begin
                overrun = i_rx_valid;
                if (i_dst_ready) begin
                    rd_en    = 1'b1;
                    rd_addr  = '0;
                    rd_first = 1'b1;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                overrun = i_rx_valid;
                rd_en   = 1'b1;
                rd_last = (rd_ptr == last_idx);
                if (rd_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt  <= '0;
            chk      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_idx <= '0;
        end else begin
            tmo_cnt <= (in_frame && !tmo_hit && !i_rx_valid) ? tmo_cnt + TW'(1) : '0;
            if (state_q == S_LEN && state_d == S_PAYLOAD) begin
                last_idx <= PW'(32'(i_rx_data) - 32'd1);
                chk      <= i_rx_data;
                wr_ptr   <= '0;
            end
            if (wr_en) begin
                chk <= chk ^ i_rx_data;
                if (wr_ptr != last_idx) wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en && !rd_last) rd_ptr <= rd_addr + PW'(1);
        end
    end

    frame_buffer_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (MAX_LEN),
        .AW        (PW)
    ) u_buf (
        .i_clk    (i_clk),
        .i_wr_en  (wr_en),
        .i_wr_addr(wr_ptr),
        .i_wr_data(i_rx_data),
        .i_rd_en  (rd_en),
        .i_rd_addr(rd_addr),
        .o_rd_data(ram_q)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid      <= 1'b0;
            s1_first      <= 1'b0;
            s1_last       <= 1'b0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_first       <= 1'b0;
            o_last        <= 1'b0;
            o_err_chk     <= 1'b0;
            o_err_len     <= 1'b0;
            o_err_timeout <= 1'b0;
            o_overrun     <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            s1_valid      <= rd_en;
            s1_first      <= rd_first;
            s1_last       <= rd_last;
            o_valid       <= s1_valid;
            o_first       <= s1_first;
            o_last        <= s1_last;
            if (s1_valid) o_data <= ram_q;
            o_err_chk     <= (err == ERR_CHK);
            o_err_len     <= (err == ERR_LEN);
            o_err_timeout <= (err == ERR_TIMEOUT);
            o_overrun     <= overrun;
            o_busy        <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_frame_assembler.sv
module tb_uart_frame_assembler;

    localparam int ML  = 256;
    localparam int TMO = 200;

    localparam int EV_CHK = 1;
    localparam int EV_LEN = 2;
    localparam int EV_TMO = 3;
    localparam int EV_OVR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       dst_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_first, o_last;
    logic       o_err_chk, o_err_len, o_err_timeout, o_overrun, o_busy;

    always #5 clk = ~clk;

    uart_frame_assembler #(
        .DATA_WIDTH    (8),
        .MAX_LEN       (ML),
        .SOF_BYTE      (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_dst_ready  (dst_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_first      (o_first),
        .o_last       (o_last),
        .o_err_chk    (o_err_chk),
        .o_err_len    (o_err_len),
        .o_err_timeout(o_err_timeout),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        logic       l;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    ev_q[$];
    logic [7:0] hold_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic ev_check(input int got);
        checks++;
        if (ev_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual=%0d expected=none t=%0t", got, $time);
        end else begin
            int e;
            e = ev_q.pop_front();
            if (e != got) begin
                errors++;
                $display("FAIL event actual=%0d expected=%0d t=%0t", got, e, $time);
            end
        end
    endtask

    // Scoreboard monitor: compares every presented beat and pulse.
    always @(negedge clk) begin
        if (rst) begin
            hold_exp = '0;
        end else begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h expected=none t=%0t", o_data, $time);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat", {22'd0, o_data, o_first, o_last}, {22'd0, b.d, b.f, b.l});
                    hold_exp = b.d;
                end
            end else begin
                check("data_hold", {24'd0, o_data}, {24'd0, hold_exp});
            end
            if (o_err_chk)     ev_check(EV_CHK);
            if (o_err_len)     ev_check(EV_LEN);
            if (o_err_timeout) ev_check(EV_TMO);
            if (o_overrun)     ev_check(EV_OVR);
        end
    end

    // Reference model: frame-level verdict from the framing rules.
    function automatic logic [7:0] xsum(input logic [7:0] len, input logic [7:0] pl[$]);
        logic [7:0] x;
        x = len;
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    task automatic model_frame(input logic [7:0] len, input logic [7:0] pl[$], input logic [7:0] cb);
        if (len < 2 || int'(len) > ML) begin
            ev_q.push_back(EV_LEN);
        end else if (xsum(len, pl) == cb) begin
            foreach (pl[i]) begin
                beat_t b;
                b.d = pl[i];
                b.f = (i == 0);
                b.l = (i == pl.size() - 1);
                exp_q.push_back(b);
            end
        end else begin
            ev_q.push_back(EV_CHK);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        repeat (gap) @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$], input logic [7:0] cb,
                              input int unsigned glo, input int unsigned ghi);
        send_byte(8'hA5, $urandom_range(ghi, glo));
        send_byte(len, $urandom_range(ghi, glo));
        foreach (pl[i]) send_byte(pl[i], $urandom_range(ghi, glo));
        send_byte(cb, $urandom_range(ghi, glo));
    endtask

    task automatic good_frame(input int unsigned len, input int unsigned ghi);
        logic [7:0] pl[$];
        logic [7:0] cb;
        for (int unsigned i = 0; i < len; i++) pl.push_back(8'($urandom));
        cb = xsum(8'(len), pl);
        model_frame(8'(len), pl, cb);
        send_frame(8'(len), pl, cb, 0, ghi);
    endtask

    // Called just after an active edge; expects o_valid&o_first on the second edge after.
    task automatic latency_check(input string name);
        logic [2:0] seen;
        @(negedge clk) seen[2] = o_valid;
        @(negedge clk) seen[1] = o_valid;
        @(negedge clk) seen[0] = o_valid & o_first;
        check(name, {29'd0, seen}, 32'b001);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((o_busy || exp_q.size() != 0 || ev_q.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drain_bound"}, {31'd0, n >= 5000}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] cb;
        int n;
        int vcnt;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {17'd0, o_data, o_valid, o_first, o_last, o_err_chk, o_err_len, o_err_timeout, o_overrun, o_busy},
              32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: sparse good frame, burst latency
        pl = '{8'h11, 8'h22, 8'h33};
        cb = xsum(8'd3, pl);
        model_frame(8'd3, pl, cb);
        send_frame(8'd3, pl, cb, 10, 10);
        latency_check("t1_latency");
        wait_drain("t1");

        // 2: bad checksum, then LEN=2 frame
        model_frame(8'd3, pl, 8'h01);
        send_frame(8'd3, pl, 8'h01, 10, 10);
        wait_drain("t2a");
        pl = '{8'hAA, 8'h55};
        model_frame(8'd2, pl, 8'hFD);
        send_frame(8'd2, pl, 8'hFD, 2, 5);
        wait_drain("t2b");

        // 3: garbage ignored, illegal lengths
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'h13, 2);
        pl = {};
        model_frame(8'd1, pl, 8'h00);
        send_byte(8'hA5, 3);
        send_byte(8'h01, 3);
        model_frame(8'd0, pl, 8'h00);
        send_byte(8'hA5, 3);
        send_byte(8'h00, 3);
        wait_drain("t3");

        // largest legal frame, back-to-back bytes
        good_frame(255, 0);
        wait_drain("t3_max");

        // 4: timeout in payload, exact timing
        ev_q.push_back(EV_TMO);
        send_byte(8'hA5, 3);
        send_byte(8'h04, 3);
        send_byte(8'h01, 3);
        send_byte(8'h02, 3);
        n = 0;
        while (n < TMO + 20) begin
            @(negedge clk);
            n++;
            if (n == 100) check("t4_busy_mid", {31'd0, o_busy}, 32'd1);
            if (o_err_timeout) break;
        end
        check("t4_timeout_clk", n, TMO + 1);
        @(negedge clk);
        check("t4_busy_fall", {31'd0, o_busy}, 32'd0);
        good_frame(6, 4);
        wait_drain("t4_after");

        // SOF landing on the timeout clock is dropped
        ev_q.push_back(EV_TMO);
        send_byte(8'hA5, 2);
        send_byte(8'h04, 2);
        send_byte(8'hA5, TMO - 1);
        send_byte(8'h02, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h55, 1);
        send_byte(8'hFD, 1);
        wait_drain("t4_tmo_sof");

        // one clock short of timeout is still accepted
        pl = '{8'h3C, 8'h7E};
        cb = xsum(8'd2, pl);
        model_frame(8'd2, pl, cb);
        send_byte(8'hA5, 1);
        send_byte(8'h02, 1);
        send_byte(8'h3C, TMO - 2);
        send_byte(8'h7E, 1);
        send_byte(cb, 1);
        wait_drain("t4_edge");

        // 5: destination not ready, overrun during wait
        dst_ready = 1'b0;
        good_frame(4, 3);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vcnt += int'(o_valid);
        end
        ev_q.push_back(EV_OVR);
        send_byte(8'($urandom), 0);
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            vcnt += int'(o_valid);
        end
        check("t5_no_valid_while_low", vcnt, 0);
        @(posedge clk);
        #1;
        dst_ready = 1'b1;
        latency_check("t5_latency");
        wait_drain("t5");

        // SOF on the clock the burst ends is an overrun and dropped
        good_frame(5, 2);
        ev_q.push_back(EV_OVR);
        send_byte(8'hA5, 4);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        send_byte(8'hFD, 0);
        wait_drain("t5_end");

        // 6: reset mid-burst
        good_frame(5, 2);
        n = 0;
        while (!(o_valid && o_first) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_burst_seen", {31'd0, n >= 100}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_drop", {28'd0, o_valid, o_first, o_last, o_busy}, 32'd0);
        exp_q.delete();
        ev_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        good_frame(5, 3);
        wait_drain("t6_after");

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            int unsigned kind;
            kind = $urandom_range(99);
            if ($urandom_range(3) == 0) begin
                for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
                    logic [7:0] gb;
                    gb = 8'($urandom);
                    if (gb == 8'hA5) gb = 8'h5A;
                    send_byte(gb, $urandom_range(5));
                end
            end
            if (kind < 12) begin
                logic [7:0] bl;
                bl = 8'($urandom_range(1));
                pl = {};
                model_frame(bl, pl, 8'h00);
                send_byte(8'hA5, $urandom_range(4));
                send_byte(bl, $urandom_range(4));
            end else begin
                int unsigned len;
                bit rdy;
                len = ($urandom_range(9) == 0) ? $urandom_range(255, 200) : $urandom_range(24, 2);
                pl = {};
                for (int unsigned i = 0; i < len; i++) pl.push_back(8'($urandom));
                cb = xsum(8'(len), pl);
                if (kind < 30) cb ^= 8'($urandom_range(255, 1));
                rdy = ($urandom_range(3) != 0);
                dst_ready = rdy;
                model_frame(8'(len), pl, cb);
                send_frame(8'(len), pl, cb, 0, 4);
                if (!rdy) begin
                    repeat ($urandom_range(12)) @(posedge clk);
                    #1;
                    dst_ready = 1'b1;
                end
            end
            wait_drain("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
